// File: rtl/wb_instr_prefetch.sv
// Wishbone classic instruction prefetcher: streams sequential words into a show-ahead FIFO.
// Optional PREFETCH_STATS_EN adds fetch/flush event counters.
module wb_instr_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] adr_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_err_o,
    input  logic        instr_ready_i
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0] fetch_count_o,
    output logic [31:0] flush_count_o
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALT} state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q;
    logic [31:0]     data_mem [DEPTH];
    logic [31:0]     pc_mem   [DEPTH];
    logic            err_mem  [DEPTH];
    logic            push, push_err, pop, free, slot_after;

    assign free       = cnt_q < (AW+1)'(DEPTH);
    // Room check uses the count before any same-cycle pop.
    assign slot_after = ({1'b0, cnt_q} + (AW+2)'(1)) < (AW+2)'(DEPTH);
    assign pop        = instr_valid_o && instr_ready_i && !redirect_i;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        push     = 1'b0;
        push_err = 1'b0;
        unique case (state_q)
            IDLE: if (free) state_d = REQ;
            REQ: begin
                if (ack_i) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                    if (!slot_after) state_d = IDLE;
                end else if (err_i) begin
                    push     = 1'b1;
                    push_err = 1'b1;
                    state_d  = HALT;
                end
            end
            DISCARD: state_d = REQ;
            HALT:    state_d = HALT;
        endcase
        // Redirect wins over any termination seen this cycle.
        if (redirect_i) begin
            push     = 1'b0;
            push_err = 1'b0;
            pc_d     = redirect_pc_i & 32'hFFFF_FFFC;
            state_d  = (state_q == REQ) ? DISCARD : REQ;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (redirect_i) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + AW'(1);
                if (pop)  rd_q <= rd_q + AW'(1);
                unique case ({push, pop})
                    2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                    2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_q] <= push_err ? 32'h0 : dat_i;
            pc_mem[wr_q]   <= pc_q;
            err_mem[wr_q]  <= push_err;
        end
    end

    assign cyc_o         = (state_q == REQ);
    assign stb_o         = (state_q == REQ);
    assign adr_o         = pc_q;
    assign we_o          = 1'b0;
    assign sel_o         = 4'b1111;
    assign instr_valid_o = (cnt_q != '0);
    assign instr_o       = data_mem[rd_q];
    assign instr_pc_o    = pc_mem[rd_q];
    assign instr_err_o   = err_mem[rd_q];

`ifdef PREFETCH_STATS_EN
    logic [31:0] fetch_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (push && !push_err) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (redirect_i)        flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign fetch_count_o = fetch_cnt_q;
    assign flush_count_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_wb_instr_prefetch.sv
// Bench for wb_instr_prefetch: Wishbone slave model, stream-level reference model, directed + random phases.
module tb_wb_instr_prefetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, redirect = 1'b0, ready = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
    logic [31:0] dat, adr, instr, ipc;
    logic        cyc, stb, we, valid, ierr;
    logic [3:0]  sel;
`ifdef PREFETCH_STATS_EN
    logic [31:0] fetch_cnt, flush_cnt;
`endif

    wb_instr_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .adr_o(adr), .cyc_o(cyc), .stb_o(stb), .we_o(we),
        .sel_o(sel), .dat_i(dat), .ack_i(ack), .err_i(err), .rty_i(rty),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(ipc), .instr_err_o(ierr),
        .instr_ready_i(ready)
`ifdef PREFETCH_STATS_EN
        , .fetch_count_o(fetch_cnt), .flush_count_o(flush_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction
    assign dat = mem_word(adr);

    // Slave: terminates one cycle after it sees stb, never two cycles in a row.
    int          rty_pct = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0, rty_addr = 32'hFFFF_FFFF;
    int          rty_hits = 0, rty_limit = 0;
    logic        wait_c = 1'b0;
    always @(negedge clk) begin
        if (ack || err || rty) begin
            ack = 1'b0; err = 1'b0; rty = 1'b0;
            wait_c = cyc && stb;
        end else if (wait_c) begin
            wait_c = 1'b0;
            if (err_en && adr == err_addr) err = 1'b1;
            else if (adr == rty_addr && rty_hits < rty_limit) begin
                rty = 1'b1; rty_hits++;
            end else if (int'($urandom_range(99)) < rty_pct) rty = 1'b1;
            else ack = 1'b1;
        end else wait_c = cyc && stb;
    end

    typedef struct packed {logic [31:0] instr; logic [31:0] pc; logic err;} ent_t;
    ent_t        log_q[$];
    int          n_chk = 0, n_fail = 0;
    logic [31:0] exp_pc = RESET_PC, prev_adr = 32'h0;
    logic        halted = 1'b0, chk_rst = 1'b0, chk_flush = 1'b0, prev_rty = 1'b0, e_err;
    int          occ = 0, acc_cnt = 0, flush_m = 0, wd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: the popped stream must be consecutive words from the last redirect target.
    always @(negedge clk) begin
        #2;
        chk("we_o", 32'(we), 32'h0);
        chk("sel_o", 32'(sel), 32'hF);
        chk("adr_align", 32'(adr[1:0]), 32'h0);
        chk("stb_eq_cyc", 32'(stb), 32'(cyc));
        if (chk_rst) begin
            chk("rst_cyc", 32'(cyc), 32'h0);
            chk("rst_valid", 32'(valid), 32'h0);
            chk("rst_adr", adr, RESET_PC);
        end
        if (chk_flush) chk("flush_empty", 32'(valid), 32'h0);
        if (prev_rty && cyc && !chk_flush && !chk_rst) chk("rty_adr_hold", adr, prev_adr);
        chk("valid_vs_occ", 32'(valid), 32'(occ != 0));
        if (halted) chk("halt_no_cyc", 32'(cyc), 32'h0);
        prev_adr = adr;
        prev_rty = cyc && rty && !redirect && !rst;
        if (rst) begin
            exp_pc = RESET_PC; halted = 1'b0; occ = 0; acc_cnt = 0; flush_m = 0; wd = 0;
            chk_rst = 1'b1; chk_flush = 1'b0;
        end else begin
            chk_rst = 1'b0;
            if (redirect) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
                halted = 1'b0; occ = 0; flush_m++; wd = 0;
                chk_flush = 1'b1;
            end else begin
                chk_flush = 1'b0;
                if (cyc && (ack || err)) begin
                    occ++;
                    if (ack) acc_cnt++;
                end
                if (valid && ready) begin
                    e_err = err_en && exp_pc == err_addr;
                    chk("pop_pc", ipc, exp_pc);
                    chk("pop_err", 32'(ierr), 32'(e_err));
                    chk("pop_instr", instr, e_err ? 32'h0 : mem_word(exp_pc));
                    log_q.push_back('{instr: instr, pc: ipc, err: ierr});
                    exp_pc = exp_pc + 32'd4;
                    occ--;
                    if (e_err) halted = 1'b1;
                    wd = 0;
                end else if (ready && !halted) begin
                    wd++;
                    if (wd > 80) begin
                        chk("fetch_stall", 32'(wd), 32'h0);
                        wd = 0;
                    end
                end
                chk("occ_bound", 32'(occ <= DEPTH && occ >= 0), 32'h1);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        int base, k;
        // 1: in-order stream from RESET_PC
        ready = 1'b1;
        do_reset();
        base = log_q.size();
        step(20);
        chk("t1_count", 32'(log_q.size() - base >= 4), 32'h1);
        if (log_q.size() - base >= 4)
            for (int i = 0; i < 4; i++) begin
                chk("t1_pc", log_q[base+i].pc, 32'(i * 4));
                chk("t1_instr", log_q[base+i].instr, 32'hC0DE_0000 + 32'(i * 4));
                chk("t1_err", 32'(log_q[base+i].err), 32'h0);
            end

        // 2: consumer stalled, FIFO fills and the bus goes quiet
        ready = 1'b0;
        do_reset();
        step(30);
        chk("t2_acks", 32'(acc_cnt), 32'd4);
        chk("t2_cyc", 32'(cyc), 32'h0);
        chk("t2_valid", 32'(valid), 32'h1);
        chk("t2_adr", adr, 32'h10);
        ready = 1'b1;
        step(10);

        // 3: redirect while an ack is due next cycle
        do_reset();
        step(3);
        k = 0;
        while (!(cyc && !ack && !err && !rty) && k < 20) begin step(); k++; end
        chk("t3_wait", 32'(k < 20), 32'h1);
        redirect = 1'b1; redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        base = log_q.size();
        chk("t3_discard_cyc", 32'(cyc), 32'h0);
        chk("t3_empty", 32'(valid), 32'h0);
        step();
        chk("t3_adr", adr, 32'h100);
        chk("t3_cyc", 32'(cyc), 32'h1);
        step(15);
        chk("t3_count", 32'(log_q.size() > base), 32'h1);
        if (log_q.size() > base) begin
            chk("t3_pc", log_q[base].pc, 32'h100);
            chk("t3_instr", log_q[base].instr, 32'hC0DE_0100);
        end
`ifdef PREFETCH_STATS_EN
        chk("t3_flush_cnt", flush_cnt, 32'd1);
        chk("t3_fetch_cnt", fetch_cnt, 32'(acc_cnt));
`endif

        // 4: bus error halts fetching
        err_en = 1'b1; err_addr = 32'h8;
        do_reset();
        base = log_q.size();
        step(30);
        chk("t4_count", 32'(log_q.size() - base), 32'd3);
        if (log_q.size() - base == 3) begin
            chk("t4_pc", log_q[base+2].pc, 32'h8);
            chk("t4_err", 32'(log_q[base+2].err), 32'h1);
            chk("t4_instr", log_q[base+2].instr, 32'h0);
        end
        chk("t4_cyc", 32'(cyc), 32'h0);
        step(10);
        chk("t4_still", 32'(log_q.size() - base), 32'd3);
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        err_en = 1'b0;
        step(5);

        // 5: two retries on 0x4 then ack
        rty_addr = 32'h4; rty_limit = rty_hits + 2;
        do_reset();
        base = log_q.size();
        step(25);
        chk("t5_rty_hits", 32'(rty_limit - rty_hits), 32'h0);
        chk("t5_count", 32'(log_q.size() - base >= 3), 32'h1);
        if (log_q.size() - base >= 3) begin
            chk("t5_pc1", log_q[base+1].pc, 32'h4);
            chk("t5_instr1", log_q[base+1].instr, 32'hC0DE_0004);
            chk("t5_pc2", log_q[base+2].pc, 32'h8);
        end
        rty_addr = 32'hFFFF_FFFF;

        // 6: address wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        base = log_q.size();
        step(15);
        chk("t6_count", 32'(log_q.size() - base >= 2), 32'h1);
        if (log_q.size() - base >= 2) begin
            chk("t6_pc0", log_q[base].pc, 32'hFFFF_FFFC);
            chk("t6_instr0", log_q[base].instr, 32'hC0DE_FFFC);
            chk("t6_pc1", log_q[base+1].pc, 32'h0);
            chk("t6_instr1", log_q[base+1].instr, 32'hC0DE_0000);
        end

        // Random: stalls, retries, redirects, errors, one mid-stream reset
        err_en = 1'b1; err_addr = 32'h40; rty_pct = 20;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            ready = ($urandom_range(3) != 0);
            if ($urandom_range(39) == 0) begin
                redirect = 1'b1;
                redirect_pc = ($urandom_range(7) == 0) ? (32'hFFFF_FF00 | ($urandom() & 32'hFF))
                                                       : ($urandom() & 32'h3FF);
            end else redirect = 1'b0;
            rst = (c == 1500);
            step();
        end
        rst = 1'b0; redirect = 1'b0;
        step(3);
`ifdef PREFETCH_STATS_EN
        chk("rnd_flush_cnt", flush_cnt, 32'(flush_m));
        chk("rnd_fetch_cnt", fetch_cnt, 32'(acc_cnt));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
